// File: rtl/i2s_to_wb_dma_pkg.sv
// i2s_to_wb_dma_pkg: shared state encodings and address helpers for the I2S Wishbone DMA masters.
package i2s_to_wb_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_BUS   = 3'b010,
        ST_ERROR = 3'b100
    } state_e;

    // Shift that turns a word offset into a byte offset for a given bus width.
    function automatic int adr_shift(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/i2s_to_wb_dma_addr_gen.sv
// i2s_to_wb_dma_addr_gen: circular word-offset counter with wrap compare and byte-address adder.
module i2s_to_wb_dma_addr_gen #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int SHIFT      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  adv,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic [ADDR_WIDTH-1:0] adr,
    output logic                  last
);

    logic [LEN_WIDTH-1:0] off_q, off_d, off_eff;

    // The address follows the post-advance offset so a back-to-back write lands on the next slot.
    always_comb begin
        last    = (length <= LEN_WIDTH'(1)) || (off_q == length - 1'b1);
        off_eff = adv ? (last ? '0 : off_q + 1'b1) : off_q;
        off_d   = clr ? '0 : off_eff;
        adr     = base + (ADDR_WIDTH'(off_eff) << SHIFT);
    end

    always_ff @(posedge clk) begin
        if (rst) off_q <= '0;
        else     off_q <= off_d;
    end

endmodule

// File: rtl/i2s_to_wb_dma_wr_master.sv
// i2s_to_wb_dma_wr_master: drains the receive FIFO into a circular memory buffer over Wishbone.
module i2s_to_wb_dma_wr_master
    import i2s_to_wb_dma_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                    dma_clk_i,
    input  logic                    dma_rst_i,
    input  logic                    dma_enable,
    input  logic [ADDR_WIDTH-1:0]   dma_base_addr,
    input  logic [LEN_WIDTH-1:0]    dma_length,
    input  logic                    fifo_empty,
    input  logic [DATA_WIDTH-1:0]   fifo_rd_data,
    output logic                    fifo_rd_enable,
    output logic                    dma_cyc_o,
    output logic                    dma_stb_o,
    output logic                    dma_we_o,
    output logic [ADDR_WIDTH-1:0]   dma_adr_o,
    output logic [DATA_WIDTH-1:0]   dma_dat_o,
    output logic [DATA_WIDTH/8-1:0] dma_sel_o,
    input  logic                    dma_ack_i,
    input  logic                    dma_err_i,
    output logic                    dma_wrap,
    output logic [LEN_WIDTH-1:0]    dma_word_count,
    output logic                    dma_fsm_error
);

    localparam int SHIFT = adr_shift(DATA_WIDTH);

    state_e                state_q, state_d;
    logic                  bus_q, bus_d;
    logic                  wrap_q, wrap_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] gen_adr;
    logic                  pop, clr, adv, last;

    i2s_to_wb_dma_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .LEN_WIDTH (LEN_WIDTH),
        .SHIFT     (SHIFT)
    ) u_addr_gen (
        .clk   (dma_clk_i),
        .rst   (dma_rst_i),
        .clr   (clr),
        .adv   (adv),
        .base  (dma_base_addr),
        .length(dma_length),
        .adr   (gen_adr),
        .last  (last)
    );

    always_comb begin
        state_d = state_q;
        bus_d   = 1'b0;
        wrap_d  = 1'b0;
        adr_d   = adr_q;
        dat_d   = dat_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        clr     = 1'b0;
        adv     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                clr     = ~dma_enable;
                cnt_d   = dma_enable ? cnt_q : '0;
                pop     = dma_enable & ~fifo_empty;
                bus_d   = pop;
                state_d = pop ? ST_BUS : ST_IDLE;
            end
            ST_BUS: begin
                // Error wins over ack: the word is dropped and the offset stays put.
                adv     = dma_ack_i & ~dma_err_i;
                pop     = adv & dma_enable & ~fifo_empty;
                bus_d   = ~dma_err_i & (~dma_ack_i | pop);
                state_d = dma_err_i ? ST_ERROR : (bus_d ? ST_BUS : ST_IDLE);
                wrap_d  = adv & last;
                cnt_d   = cnt_q + LEN_WIDTH'(adv);
            end
            ST_ERROR: state_d = ST_IDLE;
            default:  state_d = ST_ERROR;
        endcase
        if (pop) begin
            adr_d = gen_adr;
            dat_d = fifo_rd_data;
        end
    end

    always_ff @(posedge dma_clk_i) begin
        if (dma_rst_i) begin
            state_q <= ST_IDLE;
            bus_q   <= 1'b0;
            wrap_q  <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bus_q   <= bus_d;
            wrap_q  <= wrap_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fifo_rd_enable = pop;
    assign dma_cyc_o      = bus_q;
    assign dma_stb_o      = bus_q;
    assign dma_we_o       = bus_q;
    assign dma_sel_o      = {(DATA_WIDTH/8){bus_q}};
    assign dma_adr_o      = adr_q;
    assign dma_dat_o      = dat_q;
    assign dma_wrap       = wrap_q;
    assign dma_word_count = cnt_q;
    assign dma_fsm_error  = (state_q == ST_ERROR);

endmodule

// File: tb/tb_i2s_to_wb_dma_wr_master.sv
// tb_i2s_to_wb_dma_wr_master: directed self-checking bench with a FIFO model and a configurable Wishbone slave.
module tb_i2s_to_wb_dma_wr_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] base = 32'h1000;
    logic [15:0] length = 16'd4;
    logic        fifo_empty;
    logic [31:0] fifo_rd_data;
    logic        fifo_rd_enable;
    logic        cyc, stb, we;
    logic [31:0] adr, dat;
    logic [3:0]  sel;
    logic        ack, err;
    logic        wrap;
    logic [15:0] word_count;
    logic        fsm_error;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [64];
    int rp = 0, wp = 0;
    int waits = 0, err_at = -1, wcnt = 0, wr_idx = 0;
    int n_wr = 0, pops = 0, bad_pops = 0, wraps = 0, wrap_at = -1, errs = 0, stb_cyc = 0, unstable = 0;
    logic [31:0] log_adr [64];
    logic [31:0] log_dat [64];
    logic        hold_v = 1'b0;
    logic [31:0] hold_adr = '0, hold_dat = '0;
    logic        resp;

    always #5 clk = ~clk;

    assign fifo_empty   = (rp == wp);
    assign fifo_rd_data = mem[rp[5:0]];
    assign resp         = stb && (wcnt >= waits);
    assign err          = resp && (wr_idx == err_at);
    assign ack          = resp && !err;

    i2s_to_wb_dma_wr_master dut (
        .dma_clk_i     (clk),
        .dma_rst_i     (rst),
        .dma_enable    (enable),
        .dma_base_addr (base),
        .dma_length    (length),
        .fifo_empty    (fifo_empty),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_enable(fifo_rd_enable),
        .dma_cyc_o     (cyc),
        .dma_stb_o     (stb),
        .dma_we_o      (we),
        .dma_adr_o     (adr),
        .dma_dat_o     (dat),
        .dma_sel_o     (sel),
        .dma_ack_i     (ack),
        .dma_err_i     (err),
        .dma_wrap      (wrap),
        .dma_word_count(word_count),
        .dma_fsm_error (fsm_error)
    );

    always @(posedge clk) begin
        if (fifo_rd_enable) begin
            pops <= pops + 1;
            if (rp == wp) bad_pops <= bad_pops + 1;
            rp <= rp + 1;
        end
        if (wrap) begin
            wraps   <= wraps + 1;
            wrap_at <= n_wr;
        end
        if (fsm_error) errs <= errs + 1;
        if (stb) stb_cyc <= stb_cyc + 1;
        if (hold_v && (!stb || adr != hold_adr || dat != hold_dat)) unstable <= unstable + 1;
        hold_v   <= stb && !resp;
        hold_adr <= adr;
        hold_dat <= dat;
        if (!stb) wcnt <= 0;
        else if (resp) begin
            wcnt   <= 0;
            wr_idx <= wr_idx + 1;
            if (ack) begin
                log_adr[n_wr[5:0]] <= adr;
                log_dat[n_wr[5:0]] <= dat;
                n_wr <= n_wr + 1;
            end
        end else wcnt <= wcnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wp[5:0]] = 32'hC0DE_0000 + wp;
            wp = wp + 1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; enable = 1'b0; waits = 0; err_at = -1;
        base = 32'h1000; length = 16'd4;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({cyc, stb, we, sel, adr, dat, fifo_rd_enable, wrap, word_count, fsm_error} !== '0) begin
            errors++;
            $display("FAIL reset_outputs cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h pop=%b wrap=%b cnt=%0d ferr=%b, required all zero",
                     cyc, stb, we, sel, adr, dat, fifo_rd_enable, wrap, word_count, fsm_error);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_adr [6] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h1000, 32'h1004};
        int w0, p0, r0, s0, k0;
        do_reset();
        w0 = n_wr; p0 = pops; r0 = wraps; s0 = stb_cyc; k0 = wp;
        load(6);
        enable = 1'b1;
        tick(12);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (log_adr[w0+i] !== exp_adr[i] || log_dat[w0+i] !== 32'hC0DE_0000 + k0 + i) begin
                errors++;
                $display("FAIL wrap_write[%0d] adr=%h dat=%h, required adr=%h dat=%h",
                         i, log_adr[w0+i], log_dat[w0+i], exp_adr[i], 32'hC0DE_0000 + k0 + i);
            end
        end
        checks++;
        if (n_wr - w0 != 6 || pops - p0 != 6) begin
            errors++;
            $display("FAIL wrap_counts writes=%0d pops=%0d, required 6 and 6", n_wr - w0, pops - p0);
        end
        checks++;
        if (wraps - r0 != 1 || wrap_at - w0 != 4) begin
            errors++;
            $display("FAIL wrap_pulse count=%0d after_write=%0d, required 1 after 4", wraps - r0, wrap_at - w0);
        end
        checks++;
        if (word_count !== 16'd6) begin
            errors++;
            $display("FAIL wrap_word_count got %0d, required 6", word_count);
        end
        checks++;
        if (stb_cyc - s0 != 6) begin
            errors++;
            $display("FAIL wrap_peak_rate stb cycles=%0d, required 6", stb_cyc - s0);
        end
    endtask

    task automatic test_wait_states();
        int w0, p0, u0, k0;
        do_reset();
        waits = 3;
        w0 = n_wr; p0 = pops; u0 = unstable; k0 = wp;
        load(3);
        enable = 1'b1;
        tick(20);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (log_adr[w0+i] !== 32'h1000 + 4*i || log_dat[w0+i] !== 32'hC0DE_0000 + k0 + i) begin
                errors++;
                $display("FAIL wait_write[%0d] adr=%h dat=%h, required adr=%h dat=%h",
                         i, log_adr[w0+i], log_dat[w0+i], 32'h1000 + 4*i, 32'hC0DE_0000 + k0 + i);
            end
        end
        checks++;
        if (unstable != u0 || pops - p0 != 3 || n_wr - w0 != 3) begin
            errors++;
            $display("FAIL wait_stability unstable=%0d pops=%0d writes=%0d, required 0, 3, 3",
                     unstable - u0, pops - p0, n_wr - w0);
        end
    endtask

    task automatic test_empty_refill();
        int w0, k2;
        do_reset();
        w0 = n_wr;
        load(2);
        enable = 1'b1;
        tick(6);
        checks++;
        if (cyc !== 1'b0 || n_wr - w0 != 2 || log_adr[w0+1] !== 32'h1004) begin
            errors++;
            $display("FAIL empty_idle cyc=%b writes=%0d adr1=%h, required 0, 2, 00001004", cyc, n_wr - w0, log_adr[w0+1]);
        end
        k2 = wp;
        load(1);
        #1;
        checks++;
        if (fifo_rd_enable !== 1'b1) begin
            errors++;
            $display("FAIL refill_pop got %b, required 1", fifo_rd_enable);
        end
        @(posedge clk); #1;
        checks++;
        if (stb !== 1'b1 || adr !== 32'h1008 || dat !== 32'hC0DE_0000 + k2) begin
            errors++;
            $display("FAIL refill_write stb=%b adr=%h dat=%h, required 1 00001008 %h", stb, adr, dat, 32'hC0DE_0000 + k2);
        end
        tick(3);
    endtask

    task automatic test_enable_drop();
        int w0, p0, k0;
        logic seen;
        do_reset();
        waits = 2;
        w0 = n_wr; p0 = pops; k0 = wp;
        load(3);
        enable = 1'b1;
        tick(1);
        enable = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (word_count == 16'd1) seen = 1'b1;
        end
        checks++;
        if (n_wr - w0 != 1 || pops - p0 != 1 || log_dat[w0] !== 32'hC0DE_0000 + k0 || cyc !== 1'b0) begin
            errors++;
            $display("FAIL drop_complete writes=%0d pops=%0d dat=%h cyc=%b, required 1, 1, %h, 0",
                     n_wr - w0, pops - p0, log_dat[w0], cyc, 32'hC0DE_0000 + k0);
        end
        checks++;
        if (!seen || word_count !== 16'd0) begin
            errors++;
            $display("FAIL drop_count_clear saw_one=%b final=%0d, required 1 and 0", seen, word_count);
        end
        enable = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (stb !== 1'b1 || adr !== 32'h1000 || dat !== 32'hC0DE_0001 + k0) begin
            errors++;
            $display("FAIL reenable_base stb=%b adr=%h dat=%h, required 1 00001000 %h", stb, adr, dat, 32'hC0DE_0001 + k0);
        end
        tick(10);
        enable = 1'b0;
        tick(2);
    endtask

    task automatic test_error();
        int w0, p0, e0, k0;
        do_reset();
        w0 = n_wr; p0 = pops; e0 = errs; k0 = wp;
        load(3);
        err_at = wr_idx + 1;
        enable = 1'b1;
        tick(10);
        err_at = -1;
        checks++;
        if (errs - e0 != 1) begin
            errors++;
            $display("FAIL error_pulse cycles=%0d, required 1", errs - e0);
        end
        checks++;
        if (n_wr - w0 != 2 || log_adr[w0] !== 32'h1000 || log_dat[w0] !== 32'hC0DE_0000 + k0 ||
            log_adr[w0+1] !== 32'h1004 || log_dat[w0+1] !== 32'hC0DE_0002 + k0) begin
            errors++;
            $display("FAIL error_drop writes=%0d w0=%h/%h w1=%h/%h, required 2 00001000/%h 00001004/%h",
                     n_wr - w0, log_adr[w0], log_dat[w0], log_adr[w0+1], log_dat[w0+1],
                     32'hC0DE_0000 + k0, 32'hC0DE_0002 + k0);
        end
        checks++;
        if (word_count !== 16'd2 || pops - p0 != 3) begin
            errors++;
            $display("FAIL error_counts cnt=%0d pops=%0d, required 2 and 3", word_count, pops - p0);
        end
    endtask

    task automatic test_len01();
        int w0, r0;
        for (int l = 0; l < 2; l++) begin
            do_reset();
            length = 16'(l);
            w0 = n_wr; r0 = wraps;
            load(3);
            enable = 1'b1;
            tick(8);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (log_adr[w0+i] !== 32'h1000) begin
                    errors++;
                    $display("FAIL len%0d_adr[%0d] got %h, required 00001000", l, i, log_adr[w0+i]);
                end
            end
            checks++;
            if (wraps - r0 != 3 || n_wr - w0 != 3) begin
                errors++;
                $display("FAIL len%0d_wrap wraps=%0d writes=%0d, required 3 and 3", l, wraps - r0, n_wr - w0);
            end
        end
    endtask

    task automatic test_reset_mid_bus();
        do_reset();
        waits = 5;
        load(2);
        enable = 1'b1;
        tick(2);
        checks++;
        if (stb !== 1'b1) begin
            errors++;
            $display("FAIL midbus_pre stb=%b, required 1", stb);
        end
        rst = 1'b1; enable = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({cyc, stb, we, sel, adr, dat, wrap, word_count, fsm_error, fifo_rd_enable} !== '0) begin
            errors++;
            $display("FAIL midbus_reset cyc=%b stb=%b sel=%h adr=%h dat=%h cnt=%0d, required all zero",
                     cyc, stb, sel, adr, dat, word_count);
        end
        tick(1);
        rst = 1'b0;
        waits = 0;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_wait_states();
        test_empty_refill();
        test_enable_drop();
        test_error();
        test_len01();
        test_reset_mid_bus();
        checks++;
        if (bad_pops != 0) begin
            errors++;
            $display("FAIL pop_while_empty count=%0d, required 0", bad_pops);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_to_wb_dma_wr_master.md
# i2s_to_wb_dma_wr_master

Wishbone DMA write master that drains received audio words from the receive FIFO into a circular memory buffer. Sits between the I2S receive FIFO read port and the system Wishbone bus, in the DMA clock domain. Pops one FIFO word per bus write, generates incrementing word addresses from a programmed base, and wraps at a programmed length.

## Interface
- ADDR_WIDTH, 32, Wishbone byte-address width
- DATA_WIDTH, 32, Wishbone and FIFO data width (multiple of 8)
- LEN_WIDTH, 16, width of buffer length and offset/word counters

- dma_clk_i  in  1  DMA clock; all logic on rising edge
- dma_rst_i  in  1  reset, synchronous, active-high
- dma_enable  in  1  transfer enable
- dma_base_addr  in  ADDR_WIDTH  buffer base byte address, word aligned; sampled every address computation
- dma_length  in  LEN_WIDTH  buffer length in words
- fifo_empty  in  1  FIFO empty flag
- fifo_rd_data  in  DATA_WIDTH  FIFO head word, first-word-fall-through, valid when ~fifo_empty
- fifo_rd_enable  out  1  FIFO pop strobe
- dma_cyc_o, dma_stb_o, dma_we_o  out  1 each  Wishbone cycle/strobe/write
- dma_adr_o  out  ADDR_WIDTH  Wishbone address
- dma_dat_o  out  DATA_WIDTH  Wishbone write data
- dma_sel_o  out  DATA_WIDTH/8  byte selects, all ones while dma_stb_o high, else zero
- dma_ack_i, dma_err_i  in  1 each  Wishbone acknowledge / error
- dma_wrap  out  1  one-cycle pulse on the ack of the last word of the buffer
- dma_word_count  out  LEN_WIDTH  words acked since enable, modulo 2^LEN_WIDTH
- dma_fsm_error  out  1  high while in ERROR

## Operation
- One-hot states: IDLE 3'b001, BUS 3'b010, ERROR 3'b100; any other encoding goes to ERROR next cycle.
- IDLE: if dma_enable & ~fifo_empty, then fifo_rd_enable=1 (combinational) for that cycle, register fifo_rd_data into dma_dat_o, register dma_adr_o = dma_base_addr + (offset << log2(DATA_WIDTH/8)), and go to BUS. Otherwise stay.
- IDLE with dma_enable low clears offset and dma_word_count.
- BUS: dma_cyc_o=dma_stb_o=dma_we_o=1; outputs held stable until ack or err.
  - dma_err_i (priority over ack) -> ERROR; word dropped; offset not advanced.
  - dma_ack_i: dma_word_count+1. If offset == dma_length-1, offset <= 0 and dma_wrap pulses; else offset+1. If dma_enable & ~fifo_empty, pop in the same cycle, load next word/address, stay in BUS. Otherwise go to IDLE.
- dma_enable falling during BUS: the outstanding write completes, never abandoned. No new pop follows and the FSM returns to IDLE on ack.
- dma_length 0 or 1: offset stays 0 (every word to base); dma_wrap pulses on every ack.
- ERROR: all bus strobes low, no pop; next cycle IDLE. Offset and count retained.
- Address adder truncates to ADDR_WIDTH.

## Timing
- Reset values: state IDLE; dma_cyc_o/stb_o/we_o 0, dma_sel_o 0, dma_adr_o 0, dma_dat_o 0, fifo_rd_enable 0, dma_wrap 0, dma_word_count 0, dma_fsm_error 0, offset 0.
- Bus outputs are registered. fifo_rd_enable is combinational from state, dma_enable, fifo_empty, dma_ack_i and dma_err_i.
- Pop in cycle N (IDLE) -> dma_stb_o high in cycle N+1 carrying that word.
- Ack in cycle M with data available -> next address/data in M+1 with dma_stb_o continuously high. Peak rate is 1 word/cycle with zero-wait slaves.
- Ack in M, no data -> dma_cyc_o/stb_o low in M+1.
- Exactly one pop per issued write; a pop never occurs while fifo_empty=1.
- dma_wrap and dma_word_count update in the cycle after the ack edge (registered).
- Reset mid-BUS drops the cycle immediately (strobes low next cycle); the word is lost.

## Structure
- Shared package/header: state encodings (IDLE/BUS/ERROR), byte-address shift constant.
- Single module. Optional sub-module i2s_to_wb_dma_addr_gen (offset counter, wrap compare, address adder) for reuse by the transmit-side reader.

## Test plan
- Base 0x1000, length 4, FIFO preloaded with 6 words, zero-wait ack -> writes to 0x1000, 0x1004, 0x1008, 0x100C, 0x1000, 0x1004. dma_wrap pulses once after the 4th ack. dma_word_count=6. Exactly 6 pops.
- Slave adds 3 wait states per write -> dma_adr_o/dma_dat_o stable through waits. No extra pops. Data order matches FIFO.
- FIFO empties after 2 words, then refills -> strobes drop to IDLE, resume at offset 2 (0x1008) with 1-cycle pop->stb latency.
- dma_enable deasserted while stb high and ack delayed 2 cycles -> write completes, no further pop. IDLE with enable low clears count; re-enable restarts at base.
- dma_err_i on 2nd write -> dma_fsm_error high 1 cycle, word dropped. Next write goes to 0x1004 with the 3rd FIFO word.
- dma_rst_i asserted mid-BUS, and length 0/1 cases -> all outputs reset next cycle. Length 0/1 writes every word to base with dma_wrap on each ack.
